switch_arbiter: RTL and testbench

Per-output-port switch allocator for the 5-port router. Arbitrates among the five input buffers requesting one output port and locks the winner for a whole wormhole packet, head to tail. Tracks downstream buffer credits. Its registered one-hot `grant` drives the g4x inputs of the output-port selector, which steers the crossbar mux.

---
 rtl/router_pkg.sv | 33 +++
 rtl/rr_pick.sv | 28 ++
 rtl/switch_arbiter.sv | 113 +++++++++++
 tb/tb_switch_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types and one-hot/index helpers used by the switch allocator.
package router_pkg;

    localparam int unsigned NPORT = 5;
    localparam int unsigned IDX_W = $clog2(NPORT);

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    function automatic logic [NPORT-1:0] idx_to_oh(input logic [IDX_W-1:0] idx);
        logic [NPORT-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NPORT-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Port index increment with wrap-around at NPORT.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NPORT - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of elig_i at or after ptr_i wins.
module rr_pick
    import router_pkg::*;
(
    input  logic [NPORT-1:0] elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NPORT-1:0] win_oh_c,
    output logic [IDX_W-1:0] win_idx_c
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win_idx_c = '0;
        found     = 1'b0;
        cand      = ptr_i;
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (!found && elig_i[cand]) begin
                found     = 1'b1;
                win_idx_c = cand;
            end
            cand = next_idx(cand);
        end
        win_oh_c = found ? idx_to_oh(win_idx_c) : '0;
    end

endmodule

// File: rtl/switch_arbiter.sv
// Per-output switch allocator: locks one input for a whole wormhole packet and tracks credits.
// SWITCH_ARB_RR_EN selects round-robin arbitration; otherwise input 0 has fixed highest priority.
module switch_arbiter
    import router_pkg::*;
#(
    parameter int unsigned CREDITS  = 4,
    parameter int unsigned CREDIT_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    head,
    input  logic [NPORT-1:0]    tail,
    input  logic                credit_in,
    output logic [NPORT-1:0]    grant,
    output logic                fire,
    output logic                busy,
    output logic [CREDIT_W-1:0] credits
);

    arb_state_t          state_q, state_d;
    logic [NPORT-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [IDX_W-1:0]    ptr_c;
    logic [NPORT-1:0]    win_oh_c;
    logic [IDX_W-1:0]    win_idx_c;
    logic                fire_c;

`ifdef SWITCH_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    assign ptr_c = ptr_q;
`else
    assign ptr_c = '0;
`endif

    rr_pick u_pick (
        .elig_i    (req & head),
        .ptr_i     (ptr_c),
        .win_oh_c  (win_oh_c),
        .win_idx_c (win_idx_c)
    );

    // grant is one-hot, so any overlap with req means the owner has a flit ready.
    assign fire_c  = (|(grant_q & req)) && (credits_q != '0);
    assign fire    = fire_c;
    assign grant   = grant_q;
    assign busy    = (state_q == LOCKED);
    assign credits = credits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            credits_q <= CREDIT_W'(CREDITS);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
        end
    end

`ifdef SWITCH_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
`ifdef SWITCH_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|win_oh_c) begin
                    state_d = LOCKED;
                    grant_d = win_oh_c;
                    owner_d = win_idx_c;
                end
            end
            LOCKED: begin
                if (fire_c && tail[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
`ifdef SWITCH_ARB_RR_EN
                    ptr_d   = next_idx(owner_q);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Return and consumption in the same cycle cancel; returns beyond capacity are dropped.
    always_comb begin
        credits_d = credits_q;
        if (fire_c && !credit_in) begin
            credits_d = credits_q - 1'b1;
        end else if (!fire_c && credit_in && (credits_q < CREDIT_W'(CREDITS))) begin
            credits_d = credits_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed self-checking bench for switch_arbiter (fixed priority, or round-robin with SWITCH_ARB_RR_EN).
module tb_switch_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] head;
    logic [4:0] tail;
    logic       credit_in;
    logic [4:0] grant;
    logic       fire;
    logic       busy;
    logic [2:0] credits;

    int n_checks;
    int n_fail;

    switch_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .head      (head),
        .tail      (tail),
        .credit_in (credit_in),
        .grant     (grant),
        .fire      (fire),
        .busy      (busy),
        .credits   (credits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge; outputs are observed 1 time unit later.
    task automatic cyc(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t, input logic ci);
        @(negedge clk);
        req       = r;
        head      = h;
        tail      = t;
        credit_in = ci;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req       = '0;
        head      = '0;
        tail      = '0;
        credit_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if ({grant, busy, fire, credits} !== {5'b00000, 1'b0, 1'b0, 3'd4}) begin
            $display("FAIL reset_state: grant=%b busy=%b fire=%b credits=%0d, want 00000 0 0 4",
                     grant, busy, fire, credits);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);
            n_checks++;
            if ({grant, busy, fire, credits} !== {5'b00000, 1'b0, 1'b0, 3'd4}) begin
                $display("FAIL idle_after_reset[%0d]: grant=%b busy=%b fire=%b credits=%0d, want 00000 0 0 4",
                         c, grant, busy, fire, credits);
                n_fail++;
            end
        end
    endtask

    task automatic test_packet();
        do_reset();
        cyc(5'b00110, 5'b00110, 5'b00000, 1'b0);
        n_checks++;
        if ({grant, busy, fire} !== {5'b00000, 1'b0, 1'b0}) begin
            $display("FAIL pkt_t0: grant=%b busy=%b fire=%b, want 00000 0 0", grant, busy, fire);
            n_fail++;
        end
        cyc(5'b00110, 5'b00110, 5'b00000, 1'b0);
        n_checks++;
        if ({grant, busy, fire, credits} !== {5'b00010, 1'b1, 1'b1, 3'd4}) begin
            $display("FAIL pkt_t1: grant=%b busy=%b fire=%b credits=%0d, want 00010 1 1 4",
                     grant, busy, fire, credits);
            n_fail++;
        end
        cyc(5'b00110, 5'b00100, 5'b00000, 1'b0);
        n_checks++;
        if ({grant, fire, credits} !== {5'b00010, 1'b1, 3'd3}) begin
            $display("FAIL pkt_t2: grant=%b fire=%b credits=%0d, want 00010 1 3", grant, fire, credits);
            n_fail++;
        end
        cyc(5'b00110, 5'b00100, 5'b00010, 1'b0);
        n_checks++;
        if ({grant, fire, credits} !== {5'b00010, 1'b1, 3'd2}) begin
            $display("FAIL pkt_t3: grant=%b fire=%b credits=%0d, want 00010 1 2", grant, fire, credits);
            n_fail++;
        end
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);
        n_checks++;
        if ({grant, busy, fire, credits} !== {5'b00000, 1'b0, 1'b0, 3'd1}) begin
            $display("FAIL pkt_t4: grant=%b busy=%b fire=%b credits=%0d, want 00000 0 0 1",
                     grant, busy, fire, credits);
            n_fail++;
        end
        for (int c = 0; c < 3; c++) cyc(5'b00000, 5'b00000, 5'b00000, 1'b1);
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);
        n_checks++;
        if (credits !== 3'd4) begin
            $display("FAIL pkt_refill: credits=%0d, want 4", credits);
            n_fail++;
        end
    endtask

    task automatic test_arbitration();
        logic [4:0] exp_g [12];
`ifdef SWITCH_ARB_RR_EN
        exp_g = '{5'b00000, 5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100,
                  5'b00000, 5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b00001};
`else
        exp_g = '{5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00001,
                  5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00001};
`endif
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cyc(5'b11111, 5'b11111, 5'b11111, 1'b1);
            n_checks++;
            if ({grant, fire, credits} !== {exp_g[c], 1'(c % 2), 3'd4}) begin
                $display("FAIL arb_cycle[%0d]: grant=%b fire=%b credits=%0d, want %b %0d 4",
                         c, grant, fire, credits, exp_g[c], c % 2);
                n_fail++;
            end
        end
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);
        n_checks++;
        if ({grant, busy} !== {5'b00000, 1'b0}) begin
            $display("FAIL arb_drain: grant=%b busy=%b, want 00000 0", grant, busy);
            n_fail++;
        end
    endtask

    task automatic test_credit_starvation();
        do_reset();
        cyc(5'b01000, 5'b01000, 5'b00000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc(5'b01000, 5'b00000, 5'b00000, 1'b0);
            n_checks++;
            if ({grant, fire, credits} !== {5'b01000, 1'b1, 3'(4 - c)}) begin
                $display("FAIL drain[%0d]: grant=%b fire=%b credits=%0d, want 01000 1 %0d",
                         c, grant, fire, credits, 4 - c);
                n_fail++;
            end
        end
        // Input 0 now presents a head flit while input 3 owns the output.
        for (int c = 0; c < 2; c++) begin
            cyc(5'b01001, 5'b00001, 5'b00000, 1'b0);
            n_checks++;
            if ({grant, busy, fire, credits} !== {5'b01000, 1'b1, 1'b0, 3'd0}) begin
                $display("FAIL starved[%0d]: grant=%b busy=%b fire=%b credits=%0d, want 01000 1 0 0",
                         c, grant, busy, fire, credits);
                n_fail++;
            end
        end
        cyc(5'b01001, 5'b00001, 5'b00000, 1'b1);
        n_checks++;
        if ({fire, credits} !== {1'b0, 3'd0}) begin
            $display("FAIL credit_pulse: fire=%b credits=%0d, want 0 0", fire, credits);
            n_fail++;
        end
        cyc(5'b01001, 5'b00001, 5'b00000, 1'b0);
        n_checks++;
        if ({grant, fire, credits} !== {5'b01000, 1'b1, 3'd1}) begin
            $display("FAIL one_fire: grant=%b fire=%b credits=%0d, want 01000 1 1", grant, fire, credits);
            n_fail++;
        end
        cyc(5'b01001, 5'b00001, 5'b00000, 1'b1);
        n_checks++;
        if ({grant, fire, credits} !== {5'b01000, 1'b0, 3'd0}) begin
            $display("FAIL back_to_zero: grant=%b fire=%b credits=%0d, want 01000 0 0", grant, fire, credits);
            n_fail++;
        end
        cyc(5'b00001, 5'b00001, 5'b00000, 1'b1);
        n_checks++;
        if ({grant, busy, fire, credits} !== {5'b01000, 1'b1, 1'b0, 3'd1}) begin
            $display("FAIL stall: grant=%b busy=%b fire=%b credits=%0d, want 01000 1 0 1",
                     grant, busy, fire, credits);
            n_fail++;
        end
        cyc(5'b01001, 5'b00001, 5'b00000, 1'b1);
        n_checks++;
        if ({fire, credits} !== {1'b1, 3'd2}) begin
            $display("FAIL fire_and_credit: fire=%b credits=%0d, want 1 2", fire, credits);
            n_fail++;
        end
        cyc(5'b01001, 5'b00001, 5'b01000, 1'b0);
        n_checks++;
        if ({fire, credits} !== {1'b1, 3'd2}) begin
            $display("FAIL fire_credit_hold: fire=%b credits=%0d, want 1 2", fire, credits);
            n_fail++;
        end
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b1);
        n_checks++;
        if ({grant, busy, credits} !== {5'b00000, 1'b0, 3'd1}) begin
            $display("FAIL tail_release: grant=%b busy=%b credits=%0d, want 00000 0 1", grant, busy, credits);
            n_fail++;
        end
        for (int c = 0; c < 3; c++) cyc(5'b00000, 5'b00000, 5'b00000, 1'b1);
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);
        n_checks++;
        if (credits !== 3'd4) begin
            $display("FAIL credit_saturate: credits=%0d, want 4", credits);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(5'b10000, 5'b10000, 5'b00000, 1'b0);
        for (int c = 0; c < 3; c++) cyc(5'b10000, 5'b00000, 5'b00000, 1'b0);
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);
        n_checks++;
        if ({grant, busy, fire, credits} !== {5'b10000, 1'b1, 1'b0, 3'd1}) begin
            $display("FAIL pre_reset_lock: grant=%b busy=%b fire=%b credits=%0d, want 10000 1 0 1",
                     grant, busy, fire, credits);
            n_fail++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({grant, busy, fire, credits} !== {5'b00000, 1'b0, 1'b0, 3'd4}) begin
            $display("FAIL async_reset: grant=%b busy=%b fire=%b credits=%0d, want 00000 0 0 4",
                     grant, busy, fire, credits);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);
        n_checks++;
        if ({grant, busy, credits} !== {5'b00000, 1'b0, 3'd4}) begin
            $display("FAIL post_reset_idle: grant=%b busy=%b credits=%0d, want 00000 0 4", grant, busy, credits);
            n_fail++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = '0;
        head      = '0;
        tail      = '0;
        credit_in = 1'b0;
        test_reset();
        test_packet();
        test_arbitration();
        test_credit_starvation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
